// File: rtl/hex_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : hex_display_driver
//  Purpose  : 4-digit multiplexed seven-segment driver for a 16-bit hex word,
//             with tear-free updates, leading-zero blanking and blink.
//  Revision : 1.0  initial release
// ============================================================================
module hex_display_driver #(
   parameter int PRESCALE       = 4,
   parameter int BLINK_FRAMES   = 8,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        Clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] data,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [3:0]  Anode,
   output logic [6:0]  Seg,
   output logic        DP,
   output logic        ack
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FW = $clog2(BLINK_FRAMES) + 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state;
   logic [15:0]   shadow;
   logic [15:0]   active;
   logic          pending;
   logic [PW-1:0] presc;
   logic [1:0]    index;
   logic          blink_on;
   logic [FW-1:0] frame_cnt;

   logic          boundary;
   logic          transfer;
   logic [3:0]    nibble;
   logic          lead_zero;
   logic [6:0]    glyph;
   logic [3:0]    anode_nxt;
   logic [6:0]    seg_nxt;

   assign DP = SEG_ACTIVE_LOW;

   assign boundary = (state == ST_RUN) && (presc == PRE_LAST) && (index == 2'd0);
   // The first word after Idle is shown at once; later words wait for a frame edge.
   assign transfer = pending && ((state == ST_IDLE) || boundary);

   assign nibble    = active[{index, 2'b00} +: 4];
   assign lead_zero = blank_lz && (index != 2'd0) && ((active >> {index, 2'b00}) == 16'h0000);

   always_comb begin
      glyph = 7'h00;
      case (nibble)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   end

   always_comb begin
      anode_nxt = 4'hF;
      seg_nxt   = SEG_OFF;
      if (state == ST_RUN) begin
         if (!(blink_en && !blink_on)) begin
            anode_nxt = ~(4'b0001 << index);
         end
         if (!lead_zero) begin
            seg_nxt = SEG_ACTIVE_LOW ? ~glyph : glyph;
         end
      end
   end

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shadow    <= 16'h0000;
         active    <= 16'h0000;
         pending   <= 1'b0;
         presc     <= '0;
         index     <= 2'd3;
         blink_on  <= 1'b1;
         frame_cnt <= '0;
         Anode     <= 4'hF;
         Seg       <= SEG_OFF;
         ack       <= 1'b0;
      end else begin
         Anode <= anode_nxt;
         Seg   <= seg_nxt;
         ack   <= transfer;

         if (transfer) begin
            active <= shadow;
         end
         // A load on the transfer cycle stays pending for the next boundary.
         if (load) begin
            shadow  <= data;
            pending <= 1'b1;
         end else if (transfer) begin
            pending <= 1'b0;
         end

         if (state == ST_IDLE) begin
            if (pending) begin
               state <= ST_RUN;
            end
         end else begin
            if (presc == PRE_LAST) begin
               presc <= '0;
               index <= index - 2'd1;
            end else begin
               presc <= presc + 1'b1;
            end
            if (boundary) begin
               if (frame_cnt == FRAME_LAST) begin
                  frame_cnt <= '0;
                  blink_on  <= ~blink_on;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
